// File: rtl/johnson_decoder.sv
// johnson_decoder
// Decodes Johnson (twisted-ring) code words into a binary position, flags
// illegal words and out-of-sequence words, and tracks lock to a running
// counter.
//
// Optional feature macro: JOHNSON_DEC_ERRCNT_EN (adds the err_cnt port).
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous reset, active low
//   code     - Johnson code word
//   code_vld - code is sampled on a rising edge while high
//   idx      - binary position of the last legal word
//   idx_vld  - pulse: idx loaded from a legal word
//   ill_err  - pulse: sampled word is not a legal Johnson word
//   seq_err  - pulse: legal word that is not the successor of the previous one
//   locked   - high while the FSM is in LOCKED
//   err_cnt  - saturating error count (JOHNSON_DEC_ERRCNT_EN only)
//
// state   | meaning
// --------+-----------------------------------------------------------
// UNSYNC  | no run in progress; waiting for a legal word
// LOCKING | counting consecutive in-sequence words toward LOCK_N
// LOCKED  | LOCK_N consecutive in-sequence words seen; tracking counter
module johnson_decoder #(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 3,
    parameter int IW     = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] code,
    input  logic             code_vld,
    output logic [IW-1:0]    idx,
    output logic             idx_vld,
    output logic             ill_err,
    output logic             seq_err,
    output logic             locked
`ifdef JOHNSON_DEC_ERRCNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam int RW = $clog2(LOCK_N + 1);
    localparam logic [IW:0]   TWO_W  = (IW + 1)'(2 * WIDTH);
    localparam logic [RW-1:0] RUN_LK = RW'(LOCK_N);

    typedef enum logic [1:0] {
        UNSYNC  = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [RW-1:0]    run, run_nxt;
    logic [WIDTH-1:0] prev, prev_nxt;
    logic             have_prev, have_prev_nxt;
    logic [IW-1:0]    idx_nxt;
    logic             idx_vld_nxt, ill_err_nxt, seq_err_nxt;

    logic [WIDTH-1:0] code_p1, inv, inv_p1, succ;
    logic             low_ok, high_ok, legal, in_seq;
    logic [IW:0]      pcnt, dec;

    // A legal word is either a run of ones anchored at bit 0 (x & (x+1) == 0)
    // or a run of ones anchored at the MSB (same test on the inverted word).
    assign code_p1 = code + WIDTH'(1);
    assign inv     = ~code;
    assign inv_p1  = inv + WIDTH'(1);
    assign low_ok  = ((code & code_p1) == '0);
    assign high_ok = ((inv & inv_p1) == '0);
    assign legal   = low_ok | high_ok;

    always_comb begin
        pcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pcnt = pcnt + {{IW{1'b0}}, code[i]};
        end
    end

    assign dec    = code[WIDTH-1] ? (TWO_W - pcnt) : pcnt;
    assign succ   = {prev[WIDTH-2:0], ~prev[WIDTH-1]};
    assign in_seq = have_prev && (code == succ);

    always_comb begin
        state_nxt     = state;
        run_nxt       = run;
        prev_nxt      = prev;
        have_prev_nxt = have_prev;
        idx_nxt       = idx;
        idx_vld_nxt   = 1'b0;
        ill_err_nxt   = 1'b0;
        seq_err_nxt   = 1'b0;

        if (code_vld) begin
            if (!legal) begin
                ill_err_nxt = 1'b1;
                state_nxt   = UNSYNC;
                run_nxt     = '0;
            end else begin
                idx_vld_nxt   = 1'b1;
                idx_nxt       = dec[IW-1:0];
                prev_nxt      = code;
                have_prev_nxt = 1'b1;
                // first legal word after reset has nothing to compare against
                seq_err_nxt   = have_prev && !in_seq;

                case (state)
                    UNSYNC: begin
                        run_nxt   = RW'(1);
                        state_nxt = (LOCK_N == 1) ? LOCKED : LOCKING;
                    end
                    LOCKING: begin
                        if (in_seq) begin
                            run_nxt   = run + RW'(1);
                            state_nxt = (run_nxt >= RUN_LK) ? LOCKED : LOCKING;
                        end else begin
                            run_nxt = RW'(1);
                        end
                    end
                    LOCKED: begin
                        if (!in_seq) begin
                            state_nxt = UNSYNC;
                            run_nxt   = '0;
                        end
                    end
                    default: begin
                        state_nxt = UNSYNC;
                        run_nxt   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= UNSYNC;
            run       <= '0;
            prev      <= '0;
            have_prev <= 1'b0;
            idx       <= '0;
            idx_vld   <= 1'b0;
            ill_err   <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            run       <= run_nxt;
            prev      <= prev_nxt;
            have_prev <= have_prev_nxt;
            idx       <= idx_nxt;
            idx_vld   <= idx_vld_nxt;
            ill_err   <= ill_err_nxt;
            seq_err   <= seq_err_nxt;
        end
    end

    assign locked = (state == LOCKED);

`ifdef JOHNSON_DEC_ERRCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if ((ill_err_nxt || seq_err_nxt) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
module tb_johnson_decoder;

    localparam int W   = 4;
    localparam int LN  = 3;
    localparam int IW  = $clog2(2 * W);
    localparam int NW  = 2 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  code = '0;
    logic          code_vld = 1'b0;
    logic [IW-1:0] idx;
    logic          idx_vld, ill_err, seq_err, locked;
`ifdef JOHNSON_DEC_ERRCNT_EN
    logic [7:0]    err_cnt;
`endif

    johnson_decoder #(.WIDTH(W), .LOCK_N(LN)) dut (
        .clk      (clk),
        .rst      (rst),
        .code     (code),
        .code_vld (code_vld),
        .idx      (idx),
        .idx_vld  (idx_vld),
        .ill_err  (ill_err),
        .seq_err  (seq_err),
        .locked   (locked)
`ifdef JOHNSON_DEC_ERRCNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int vld;
        int ill;
        int serr;
        int lck;
        int err;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // reference model state: position in the 2W-long Johnson cycle
    logic [W-1:0] tbl [NW];
    int m_last, m_have, m_run, m_lck, m_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [W-1:0] w);
        int k;
        k = -1;
        for (int i = 0; i < NW; i++) if (tbl[i] == w) k = i;
        return k;
    endfunction

    task automatic model_reset();
        m_last = 0; m_have = 0; m_run = 0; m_lck = 0; m_err = 0;
    endtask

    task automatic model_sample(input logic [W-1:0] w);
        exp_t e;
        int k, ok, bad;
        k = lookup(w);
        e.ill = (k < 0);
        e.vld = (k >= 0);
        e.serr = 0;
        if (k < 0) begin
            m_run = 0;
            m_lck = 0;
        end else begin
            ok  = m_have && (k == (m_last + 1) % NW);
            bad = m_have && !ok;
            e.serr = bad;
            if (m_lck) begin
                if (bad) begin m_lck = 0; m_run = 0; end
            end else if (m_run == 0) begin
                m_run = 1;
                m_lck = (LN == 1);
            end else if (ok) begin
                m_run++;
                m_lck = (m_run >= LN);
            end else begin
                m_run = 1;
            end
            m_last = k;
            m_have = 1;
        end
        if ((e.ill || e.serr) && m_err < 255) m_err++;
        e.idx = m_last;
        e.lck = m_lck;
        e.err = m_err;
        q.push_back(e);
    endtask

    task automatic send(input logic [W-1:0] w);
        code = w;
        code_vld = 1'b1;
        model_sample(w);
        @(negedge clk);
        code_vld = 1'b0;
        code = W'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // monitor: every output pulse consumes one expected entry
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (seq_err && !idx_vld) chk("seq_err_without_idx_vld", 1, 0);
            if (idx_vld || ill_err) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("idx_vld", int'(idx_vld), e.vld);
                    chk("ill_err", int'(ill_err), e.ill);
                    chk("seq_err", int'(seq_err), e.serr);
                    chk("idx", int'(idx), e.idx);
                    chk("locked", int'(locked), e.lck);
`ifdef JOHNSON_DEC_ERRCNT_EN
                    chk("err_cnt", int'(err_cnt), e.err);
`endif
                end
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_idx"}, int'(idx), 0);
        chk({tag, "_idx_vld"}, int'(idx_vld), 0);
        chk({tag, "_ill_err"}, int'(ill_err), 0);
        chk({tag, "_seq_err"}, int'(seq_err), 0);
        chk({tag, "_locked"}, int'(locked), 0);
`ifdef JOHNSON_DEC_ERRCNT_EN
        chk({tag, "_err_cnt"}, int'(err_cnt), 0);
`endif
    endtask

    initial begin
        int r, k;
        logic [W-1:0] w;

        for (int i = 0; i < NW; i++) begin
            if (i <= W) tbl[i] = W'((1 << i) - 1);
            else        tbl[i] = W'(((1 << W) - 1) & ~((1 << (i - W)) - 1));
        end
        model_reset();

        idle(3);
        chk_zero("reset");
        rst = 1'b1;
        idle(2);

        // lock-in on an ascending run
        send(4'b0001); send(4'b0011); send(4'b0111); send(4'b1111);
        idle(1);
        chk("locked_after_run", int'(locked), 1);

        // sequence error then illegal word while locked
        send(4'b0000); send(4'b0101);
        idle(1);
        chk("unlocked_after_err", int'(locked), 0);

        // gaps and the 7->0 wrap
        send(4'b1100); idle(2);
        send(4'b1000); idle(2);
        send(4'b0000); idle(2);
        send(4'b0001); idle(2);

        // stalled counter
        send(4'b0011); send(4'b0011);
        idle(1);

        // relock, then asynchronous reset while locked
        send(4'b0111); send(4'b1111); send(4'b1110); send(4'b1100);
        idle(1);
        chk("locked_before_reset", int'(locked), 1);
        #2 rst = 1'b0;
        model_reset();
        #1 chk_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        send(4'b1110);
        idle(1);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      w = tbl[(m_last + 1) % NW];
            else if (r < 70) w = tbl[$urandom_range(0, NW - 1)];
            else if (r < 85) w = W'($urandom);
            else             w = tbl[m_last];
            send(w);
            k = $urandom_range(0, 3);
            if (k == 0) idle($urandom_range(1, 3));
        end
        idle(2);

`ifdef JOHNSON_DEC_ERRCNT_EN
        for (int n = 0; n < 300; n++) send(4'b0101);
        idle(2);
        chk("err_cnt_saturated", int'(err_cnt), 255);
`endif

        idle(3);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
